// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the multicycle MIPS controller:
//                FSM state encoding, opcode/funct constants, ALU operation
//                classes and ALU control codes.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Controller states; FETCH is encoded as zero.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    // ALU operation class from the main FSM
    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    // True for the six opcodes the controller implements.
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == C_OP_RTYPE) || (op == C_OP_LW)   || (op == C_OP_SW) ||
               (op == C_OP_BEQ)   || (op == C_OP_ADDI) || (op == C_OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller_if
//  Description : Instruction/status inputs and datapath control outputs of
//                the multicycle controller.
//                slave  : controller side (consumes op/funct/zero/memready,
//                         drives all selects and enables)
//                master : datapath side (the reverse)
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       illegal_op;

    modport slave (
        input  op, funct, zero, memready,
        output iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, alucontrol, pcen, illegal_op
    );

    modport master (
        output op, funct, zero, memready,
        input  iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, alucontrol, pcen, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// ============================================================================
//  Module      : aludec
//  Description : ALU control decoder. Maps the FSM's ALU operation class and
//                the R-type funct field onto a 3-bit ALU control code.
//  Ports       : i_aluop      - operation class (add / sub / use funct)
//                i_funct      - instr[5:0]
//                o_alucontrol - ALU control code
//  Revision    : 1.0  initial release
// ============================================================================
module aludec
    import mips_pkg::*;
(
    input  wire logic [1:0] i_aluop,
    input  wire logic [5:0] i_funct,
    output logic      [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = C_ALU_ADD;
        case (i_aluop)
            C_ALUOP_ADD: o_alucontrol = C_ALU_ADD;
            C_ALUOP_SUB: o_alucontrol = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (i_funct)
                    C_FN_ADD: o_alucontrol = C_ALU_ADD;
                    C_FN_SUB: o_alucontrol = C_ALU_SUB;
                    C_FN_AND: o_alucontrol = C_ALU_AND;
                    C_FN_OR:  o_alucontrol = C_ALU_OR;
                    C_FN_SLT: o_alucontrol = C_ALU_SLT;
                    default:  o_alucontrol = C_ALU_ADD;
                endcase
            end
            // Unused class 11 falls back to add.
            default: o_alucontrol = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Moore-FSM controller for a multicycle MIPS subset
//                (lw, sw, R-type, beq, addi, j) sharing one memory for
//                instructions and data.
//  Ports       : clk   - clock, all state changes on the rising edge
//                reset - synchronous active-high reset
//                bus   - op/funct/zero/memready in, datapath controls out
//  Parameters  : HAS_MEMREADY - 1: memready stalls FETCH/MEMRD/MEMWR,
//                               0: memory assumed to always complete
//  Revision    : 1.0  initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
#(
    parameter int HAS_MEMREADY = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mc_controller_if.slave  bus
);

    logic   w_memready;
    state_t state_q;
    state_t state_d;
    state_t w_dec_state;

    logic       w_iord;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;

    generate
        if (HAS_MEMREADY != 0) begin : g_memready
            assign w_memready = bus.memready;
        end else begin : g_no_memready
            assign w_memready = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (w_memready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYPE:       state_d = S_EXECUTE;
                    C_OP_BEQ:         state_d = S_BRANCH;
                    C_OP_ADDI:        state_d = S_ADDIEX;
                    C_OP_J:           state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (w_memready) state_d = S_MEMWB;
            S_MEMWR:   if (w_memready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. While reset is high the outputs decode as FETCH,
    // whatever state the register still holds, so an interrupted store or
    // writeback never reaches memory or the register file.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_state = reset ? S_FETCH : state_q;
        w_iord      = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regdst    = 1'b0;
        w_memtoreg  = 1'b0;
        w_regwrite  = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_pcsrc     = 2'b00;
        w_aluop     = C_ALUOP_ADD;
        w_pcwrite   = 1'b0;
        w_branch    = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                // IR and PC update only on the cycle the fetch completes.
                w_irwrite = w_memready;
                w_pcwrite = w_memready;
            end
            S_DECODE:  w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD:   w_iord = 1'b1;
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = C_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = C_ALUOP_SUB;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_ADDIWB:  w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (bus.alucontrol)
    );

    // Write enables are gated by reset directly rather than relying on the
    // FETCH decode alone.
    assign bus.iord       = w_iord;
    assign bus.irwrite    = w_irwrite  & ~reset;
    assign bus.memwrite   = w_memwrite & ~reset;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.regwrite   = w_regwrite & ~reset;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.aluop      = w_aluop;
    assign bus.pcen       = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
    assign bus.illegal_op = (w_dec_state == S_DECODE) & ~is_legal_op(bus.op) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Directed, table-driven bench for mc_controller plus
//                hand-written instruction-latency sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_controller;
    import mips_pkg::*;

    logic clk;
    logic reset;
    mc_controller_if bi ();

    mc_controller #(.HAS_MEMREADY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order:
    // {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
    //  alusrcb[1:0], pcsrc[1:0], aluop[1:0], alucontrol[2:0], pcen, illegal_op}
    localparam logic [17:0] E_RST     = 18'b0_0_0_0_0_0_0_01_00_00_010_0_0;
    localparam logic [17:0] E_FETCH   = 18'b0_1_0_0_0_0_0_01_00_00_010_1_0;
    localparam logic [17:0] E_FSTALL  = 18'b0_0_0_0_0_0_0_01_00_00_010_0_0;
    localparam logic [17:0] E_DEC     = 18'b0_0_0_0_0_0_0_11_00_00_010_0_0;
    localparam logic [17:0] E_ILL     = 18'b0_0_0_0_0_0_0_11_00_00_010_0_1;
    localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_1_10_00_00_010_0_0;
    localparam logic [17:0] E_MEMRD   = 18'b1_0_0_0_0_0_0_00_00_00_010_0_0;
    localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_1_1_0_00_00_00_010_0_0;
    localparam logic [17:0] E_MEMWR   = 18'b1_0_1_0_0_0_0_00_00_00_010_0_0;
    localparam logic [17:0] E_EX_SLT  = 18'b0_0_0_0_0_0_1_00_00_10_111_0_0;
    localparam logic [17:0] E_EX_OR   = 18'b0_0_0_0_0_0_1_00_00_10_001_0_0;
    localparam logic [17:0] E_EX_UNK  = 18'b0_0_0_0_0_0_1_00_00_10_010_0_0;
    localparam logic [17:0] E_ALUWB   = 18'b0_0_0_1_0_1_0_00_00_00_010_0_0;
    localparam logic [17:0] E_BR_T    = 18'b0_0_0_0_0_0_1_00_01_01_110_1_0;
    localparam logic [17:0] E_BR_N    = 18'b0_0_0_0_0_0_1_00_01_01_110_0_0;
    localparam logic [17:0] E_ADDIEX  = 18'b0_0_0_0_0_0_1_10_00_00_010_0_0;
    localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_1_0_00_00_00_010_0_0;
    localparam logic [17:0] E_JUMP    = 18'b0_0_0_0_0_0_0_00_10_00_010_1_0;

    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mr;
        state_t     st;    // state held during this cycle
        logic [17:0] outs; // outputs expected during this cycle
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;

    function automatic vec_t mk(input logic rst, input logic [5:0] op,
                                input logic [5:0] funct, input logic zero,
                                input logic mr, input state_t st,
                                input logic [17:0] outs);
        vec_t v;
        v.rst = rst; v.op = op; v.funct = funct; v.zero = zero;
        v.mr = mr; v.st = st; v.outs = outs;
        return v;
    endfunction

    function automatic logic [17:0] act_outs();
        return {bi.iord, bi.irwrite, bi.memwrite, bi.regdst, bi.memtoreg,
                bi.regwrite, bi.alusrca, bi.alusrcb, bi.pcsrc, bi.aluop,
                bi.alucontrol, bi.pcen, bi.illegal_op};
    endfunction

    // Run one instruction from FETCH with memready=1 and count its cycles.
    task automatic measure(input string name, input logic [5:0] op,
                           input logic [5:0] funct, input int exp_cycles);
        int n;
        bi.op = op; bi.funct = funct; bi.zero = 1'b0; bi.memready = 1'b1;
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            @(posedge clk);
            #1;
        end while (dut.state_q != S_FETCH && n < 20);
        total++;
        if (n != exp_cycles) begin
            bad++;
            $display("FAIL %s cycles: got %0d expected %0d", name, n, exp_cycles);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bi.op = 6'd0; bi.funct = 6'd0; bi.zero = 1'b0; bi.memready = 1'b1;

        // reset state
        tbl.push_back(mk(1, C_OP_LW, 0, 0, 1, S_FETCH, E_RST));
        // lw
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMADR, E_MEMADR));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMRD,  E_MEMRD));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMWB,  E_MEMWB));
        // sw
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_MEMADR, E_MEMADR));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_MEMWR,  E_MEMWR));
        // R-type slt
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_SLT, 0, 1, S_FETCH,   E_FETCH));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_SLT, 0, 1, S_DECODE,  E_DEC));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_SLT, 0, 1, S_EXECUTE, E_EX_SLT));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_SLT, 0, 1, S_ALUWB,   E_ALUWB));
        // R-type or
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_OR, 0, 1, S_FETCH,   E_FETCH));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_OR, 0, 1, S_DECODE,  E_DEC));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_OR, 0, 1, S_EXECUTE, E_EX_OR));
        tbl.push_back(mk(0, C_OP_RTYPE, C_FN_OR, 0, 1, S_ALUWB,   E_ALUWB));
        // R-type with unlisted funct -> add
        tbl.push_back(mk(0, C_OP_RTYPE, 6'b000111, 0, 1, S_FETCH,   E_FETCH));
        tbl.push_back(mk(0, C_OP_RTYPE, 6'b000111, 0, 1, S_DECODE,  E_DEC));
        tbl.push_back(mk(0, C_OP_RTYPE, 6'b000111, 0, 1, S_EXECUTE, E_EX_UNK));
        tbl.push_back(mk(0, C_OP_RTYPE, 6'b000111, 0, 1, S_ALUWB,   E_ALUWB));
        // addi
        tbl.push_back(mk(0, C_OP_ADDI, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_ADDI, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_ADDI, 0, 0, 1, S_ADDIEX, E_ADDIEX));
        tbl.push_back(mk(0, C_OP_ADDI, 0, 0, 1, S_ADDIWB, E_ADDIWB));
        // beq taken
        tbl.push_back(mk(0, C_OP_BEQ, 0, 1, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_BEQ, 0, 1, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_BEQ, 0, 1, 1, S_BRANCH, E_BR_T));
        // beq not taken
        tbl.push_back(mk(0, C_OP_BEQ, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_BEQ, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_BEQ, 0, 0, 1, S_BRANCH, E_BR_N));
        // j
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_JUMP,   E_JUMP));
        // illegal opcode
        tbl.push_back(mk(0, OP_BAD, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, OP_BAD, 0, 0, 1, S_DECODE, E_ILL));
        // FETCH stall two cycles, then j
        tbl.push_back(mk(0, C_OP_J, 0, 0, 0, S_FETCH,  E_FSTALL));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 0, S_FETCH,  E_FSTALL));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_J, 0, 0, 1, S_JUMP,   E_JUMP));
        // sw with MEMWR stall
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_MEMADR, E_MEMADR));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 0, S_MEMWR,  E_MEMWR));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 0, S_MEMWR,  E_MEMWR));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_MEMWR,  E_MEMWR));
        // sw interrupted by reset during a MEMWR stall
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 1, S_MEMADR, E_MEMADR));
        tbl.push_back(mk(0, C_OP_SW, 0, 0, 0, S_MEMWR,  E_MEMWR));
        tbl.push_back(mk(1, C_OP_SW, 0, 0, 0, S_MEMWR,  E_RST));
        // lw with MEMRD stall
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_FETCH,  E_FETCH));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_DECODE, E_DEC));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMADR, E_MEMADR));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 0, S_MEMRD,  E_MEMRD));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMRD,  E_MEMRD));
        tbl.push_back(mk(0, C_OP_LW, 0, 0, 1, S_MEMWB,  E_MEMWB));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            reset       = tbl[i].rst;
            bi.op       = tbl[i].op;
            bi.funct    = tbl[i].funct;
            bi.zero     = tbl[i].zero;
            bi.memready = tbl[i].mr;
            @(negedge clk);
            total++;
            if (dut.state_q != tbl[i].st) begin
                bad++;
                $display("FAIL row %0d state: got %0d expected %0d",
                         i, dut.state_q, tbl[i].st);
            end
            total++;
            if (act_outs() != tbl[i].outs) begin
                bad++;
                $display("FAIL row %0d outs: got %b expected %b",
                         i, act_outs(), tbl[i].outs);
            end
            @(posedge clk);
            #1;
        end

        // Table ends after MEMWB; the controller should be back in FETCH.
        total++;
        if (dut.state_q != S_FETCH) begin
            bad++;
            $display("FAIL end-of-table state: got %0d expected %0d",
                     dut.state_q, S_FETCH);
        end

        measure("lw",   C_OP_LW,    6'd0,     5);
        measure("sw",   C_OP_SW,    6'd0,     4);
        measure("rtyp", C_OP_RTYPE, C_FN_ADD, 4);
        measure("addi", C_OP_ADDI,  6'd0,     4);
        measure("beq",  C_OP_BEQ,   6'd0,     3);
        measure("j",    C_OP_J,     6'd0,     3);
        measure("ill",  OP_BAD,     6'd0,     2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Register and memory writes must never coincide.
    always @(negedge clk) begin
        if (bi.regwrite && bi.memwrite) begin
            $display("FAIL regwrite/memwrite overlap: got 1 expected 0");
        end
    end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter HAS_MEMREADY, default 1, meaning 1 = memready honoured and 0 = memready treated as constant 1.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op  input  6  instr[31:26] from instruction register.
REQ-005 SHALL have port funct  input  6  instr[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port memready  input  1  shared memory has completed the current access this cycle.
REQ-008 SHALL have outputs iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath selects and enables.
REQ-009 SHALL have outputs alusrcb, pcsrc, aluop  output  2 each; alucontrol  output  3.
REQ-010 SHALL have outputs pcen  output  1  PC load enable; illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-012 SHALL transition as follows. FETCH->DECODE. DECODE->MEMADR on lw(100011)/sw(101011), EXECUTE on R-type(000000), BRANCH on beq(000100), ADDIEX on addi(001000), JUMP on j(000010), FETCH otherwise. MEMADR->MEMRD on lw, else MEMWR. MEMRD->MEMWB. EXECUTE->ALUWB. ADDIEX->ADDIWB. MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP->FETCH.
REQ-013 SHALL hold state in FETCH, MEMRD and MEMWR while memready=0; it advances only on the edge where memready=1.
REQ-014 SHALL drive these outputs per state; every signal not listed is 0.
- FETCH: alusrcb=01; irwrite=pcwrite=memready.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=memtoreg=1.
- MEMWR: iord=memwrite=1, held for the whole stall.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-015 SHALL compute pcen = pcwrite | (branch & zero), combinationally, in the same cycle.
REQ-016 SHALL decode alucontrol as follows. aluop 00->010, 01->110. aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-017 SHALL pulse illegal_op for exactly the DECODE cycle when op matches none of the six opcodes; no register or memory write occurs for that instruction.
REQ-018 SHALL complete instructions in these cycle counts with memready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-019 SHALL never assert regwrite and memwrite in the same cycle.

Reset
REQ-020 SHALL load state FETCH on any clock edge where reset=1, including mid-instruction; the interrupted instruction is abandoned.
REQ-021 SHALL force irwrite, pcwrite, pcen, regwrite, memwrite and illegal_op to 0 while reset=1; other outputs follow the FETCH decode.
REQ-022 SHALL begin its first fetch on the first edge after reset deasserts.

Structure
REQ-023 SHALL take opcode constants, funct constants, the aluop encodings and the state enumeration from shared package mips_pkg.
REQ-024 SHALL implement the REQ-016 decode in one sub-module, aludec; the FSM and output decode stay in mc_controller.
REQ-025 SHALL be implementable in 120-400 lines of RTL, with no latches and no asynchronous logic.

Verification
REQ-026 SHALL cover lw (op=100011, memready=1): the state sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=memtoreg=1 only in cycle 5; irwrite=1 only in cycle 1.
REQ-027 SHALL cover beq (op=000100): with zero=1, pcen=1 and pcsrc=01 in cycle 3; with zero=0, pcen=0 in cycle 3; the next cycle is FETCH in both cases.
REQ-028 SHALL cover a FETCH stall: memready=0 for 2 cycles then 1 gives irwrite=pcen=0 for those 2 cycles, then 1 for one cycle, then DECODE.
REQ-029 SHALL cover R-type funct=101010: alucontrol=111 in EXECUTE, and regdst=regwrite=1 in ALUWB.
REQ-030 SHALL cover reset asserted during MEMWR with memready=0: memwrite=0 in that cycle, state=FETCH after the edge, and no regwrite occurs.
REQ-031 SHALL cover op=111111: illegal_op=1 for one cycle in DECODE, then FETCH, with regwrite=memwrite=0 throughout.
